mem_stream_reader: RTL

Read-side sequencer for the 18-bit × 256 block-RAM matrix store. On a start command it walks a contiguous, wrap-around address range in the RAM and streams the words out on a valid/ready interface, one word per cycle at full throughput. It hides the RAM's one-cycle registered read latency behind a 2-entry output buffer, so downstream backpressure never drops or duplicates a word.

---
 rtl/mem_stream_reader_if.sv | 35 +++
 rtl/mem_stream_reader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_reader_if
// Description : RAM read port plus valid/ready output stream of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stream_reader_if #(
    parameter int RAM_WIDTH     = 18,
    parameter int RAM_ADDR_BITS = 8
);
    logic                     mem_en;
    logic                     mem_rd_en;
    logic                     mem_we;
    logic [RAM_ADDR_BITS-1:0] mem_addr;
    logic [RAM_WIDTH-1:0]     mem_rdata;
    logic [RAM_WIDTH-1:0]     out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        output mem_en, mem_rd_en, mem_we, mem_addr,
        input  mem_rdata,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_en, mem_rd_en, mem_we, mem_addr,
        output mem_rdata,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_reader
// Description : Streams a wrap-around RAM address range out on valid/ready,
//               hiding the registered read latency behind a 2-entry FIFO.
//               Optional macro READER_SUM_EN adds the sum_o accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_reader #(
    parameter int RAM_WIDTH     = 18,
    parameter int RAM_ADDR_BITS = 8
) (
    input  wire                       clk,
    input  wire                       rst,
    input  wire                       start_i,
    input  wire [RAM_ADDR_BITS-1:0]   base_addr_i,
    input  wire [RAM_ADDR_BITS:0]     length_i,
    output logic                      busy_o,
    output logic                      done_o,
    mem_stream_reader_if.master       rd_if
`ifdef READER_SUM_EN
    ,
    output logic [RAM_WIDTH+RAM_ADDR_BITS-1:0] sum_o
`endif
);
    localparam int LW = RAM_ADDR_BITS + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [LW-1:0]            issue_left_q, issue_left_d;
    logic [LW-1:0]            len_q, len_d;
    logic [LW-1:0]            pop_cnt_q, pop_cnt_d;
    logic                     inflight_q, inflight_d;

    logic [RAM_WIDTH-1:0]     fifo_q [2];
    logic                     wr_ptr_q, rd_ptr_q;
    logic [1:0]               count_q;

    logic                     w_accept;
    logic                     w_valid;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_issue;
    logic                     w_last;
    logic [2:0]               w_occ;

    assign w_accept = (state_q == S_IDLE) && start_i;
    assign w_valid  = (count_q != 2'd0);
    assign w_pop    = w_valid && rd_if.out_ready;
    assign w_push   = inflight_q;
    // Occupancy after this cycle's pop; a pop implies count_q >= 1, so no underflow.
    assign w_occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_issue  = (state_q == S_RUN) && (issue_left_q != '0) && (w_occ < 3'd2);
    assign w_last   = w_valid && (pop_cnt_q == (len_q - LW'(1)));

    assign rd_if.out_valid = w_valid;
    assign rd_if.out_data  = fifo_q[rd_ptr_q];
    assign rd_if.out_last  = w_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = (length_i == '0) ? S_FIN : S_RUN;
            S_RUN:  if (w_pop && w_last) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o          = (state_q != S_IDLE);
        done_o          = (state_q == S_FIN);
        rd_if.mem_en    = w_issue;
        rd_if.mem_rd_en = w_issue;
        rd_if.mem_we    = 1'b0;
        rd_if.mem_addr  = addr_q;
    end

    always_comb begin
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        len_d        = len_q;
        pop_cnt_d    = pop_cnt_q;
        inflight_d   = w_issue;
        if (w_accept) begin
            addr_d       = base_addr_i;
            issue_left_d = length_i;
            len_d        = length_i;
            pop_cnt_d    = '0;
        end else begin
            if (w_issue) begin
                addr_d       = addr_q + RAM_ADDR_BITS'(1);
                issue_left_d = issue_left_q - LW'(1);
            end
            if (w_pop) begin
                pop_cnt_d = pop_cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            issue_left_q <= '0;
            len_q        <= '0;
            pop_cnt_q    <= '0;
            inflight_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            len_q        <= len_d;
            pop_cnt_q    <= pop_cnt_d;
            inflight_q   <= inflight_d;
        end
    end

    // The issue rule keeps occupancy at or below two, so push never hits a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (w_push) begin
                fifo_q[wr_ptr_q] <= rd_if.mem_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef READER_SUM_EN
    logic [RAM_WIDTH+RAM_ADDR_BITS-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (w_accept) begin
            sum_d = '0;
        end else if (w_pop) begin
            sum_d = sum_q + {{RAM_ADDR_BITS{1'b0}}, rd_if.out_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
`endif

endmodule
`default_nettype wire
